dmem_lsu: RTL

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_lsu.sv | 95 +++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between a core request/response port and a 32-bit word-addressed DRAM.
// Sub-word stores use byte enables; loads pick the addressed lane and sign- or zero-extend it.
module dmem_lsu #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] dram_addr,
    output logic [31:0]           dram_wr_data,
    output logic [3:0]            dram_wr_byte_en,
    output logic                  dram_wr_en,
    input  logic [31:0]           dram_rd_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t                state, state_nxt;
    logic [31:0]           off, lane, ld_data;
    logic                  accept, in_range, misaligned, err;
    logic [ADDR_WIDTH+1:0] r_off;
    logic                  r_we, r_unsigned;
    logic [1:0]            r_size;
    logic [31:0]           r_wdata;
    logic [3:0]            be;

    // Subtraction wraps for addresses below BASE_ADDR, so the unsigned range test rejects them too.
    assign off        = req_addr - BASE_ADDR;
    assign in_range   = (off >> (ADDR_WIDTH + 2)) == 32'd0;
    assign misaligned = (req_size == 2'd1 && off[0]) || (req_size == 2'd2 && off[1:0] != 2'b00);
    assign err        = req_size == 2'd3 || misaligned || !in_range;
    assign accept     = req_valid && req_ready;

    assign req_ready       = state == IDLE;
    assign resp_valid      = state == RESP;
    assign dram_addr       = r_off[ADDR_WIDTH+1:2];
    assign dram_wr_en      = state == ACCESS && r_we;
    assign be              = r_size == 2'd0 ? 4'b0001 << r_off[1:0] :
                             r_size == 2'd1 ? 4'b0011 << r_off[1:0] : 4'b1111;
    assign dram_wr_byte_en = dram_wr_en ? be : 4'b0000;
    assign dram_wr_data    = r_size == 2'd0 ? {4{r_wdata[7:0]}} :
                             r_size == 2'd1 ? {2{r_wdata[15:0]}} : r_wdata;

    // Words are always aligned, so the shifted lane is the whole word in that case.
    assign lane    = dram_rd_data >> {r_off[1:0], 3'b000};
    assign ld_data = r_size == 2'd0 ? {{24{~r_unsigned & lane[7]}}, lane[7:0]} :
                     r_size == 2'd1 ? {{16{~r_unsigned & lane[15]}}, lane[15:0]} : lane;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? (err ? RESP : ACCESS) : IDLE;
            ACCESS:  state_nxt = r_we ? RESP : CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    state_nxt = resp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            r_off      <= '0;
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                r_off      <= off[ADDR_WIDTH+1:0];
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_wdata    <= req_wdata;
                resp_rdata <= '0;
                resp_err   <= err;
            end
            if (state == CAPTURE)
                resp_rdata <= ld_data;
        end
    end
endmodule
